fir_src: RTL and testbench

FIR_SRC -- requirements
Module: fir_src

---
 rtl/fir_src_pkg.sv | 13 +
 rtl/fir_src_if.sv | 25 ++
 rtl/fir_mac_tap.sv | 25 ++
 rtl/fir_src.sv | 68 ++++++
 tb/tb_fir_src.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/fir_src_pkg.sv
// Shared constants for the fir_src four-tap FIR filter.
//   n_taps       : number of taps in the delay line
//   def_*        : default widths used by the interface, top and MAC sub-module
package fir_src_pkg;

  localparam int n_taps       = 4;
  localparam int def_w_in     = 7;   // signed sample width
  localparam int def_c_in     = 5;   // signed coefficient width
  localparam int def_y_out    = 20;  // signed output width
  localparam int def_w_muti_y = 16;  // signed product width, >= w_in + c_in
  localparam int def_w_add_y  = 20;  // signed accumulator width, >= w_muti_y + 2

endpackage

// File: rtl/fir_src_if.sv
// Data bundle of the fir_src filter. There is no handshake: a new sample and
// coefficient set is presented every clock and a result comes back every clock.
//   x_in        : signed sample (w_in)
//   c_0 .. c_3  : signed coefficients, c_0 for the newest tap (c_in)
//   y_k         : signed registered filter result (y_out)
// Modports: master drives samples/coefficients, slave (the filter) drives y_k.
interface fir_src_if
  import fir_src_pkg::*;
#(
  parameter int w_in  = def_w_in,
  parameter int c_in  = def_c_in,
  parameter int y_out = def_y_out
) ();

  logic signed [w_in-1:0]  x_in;
  logic signed [c_in-1:0]  c_0;
  logic signed [c_in-1:0]  c_1;
  logic signed [c_in-1:0]  c_2;
  logic signed [c_in-1:0]  c_3;
  logic signed [y_out-1:0] y_k;

  modport master (output x_in, c_0, c_1, c_2, c_3, input y_k);
  modport slave  (input x_in, c_0, c_1, c_2, c_3, output y_k);

endinterface

// File: rtl/fir_mac_tap.sv
// One filter tap: full-precision signed product of a delayed sample and its
// coefficient, sign-extended to the product width.
//   tap  : signed delayed sample (w_in)
//   coef : signed coefficient (c_in)
//   prod : signed product (w_muti_y)
module fir_mac_tap
  import fir_src_pkg::*;
#(
  parameter int w_in     = def_w_in,
  parameter int c_in     = def_c_in,
  parameter int w_muti_y = def_w_muti_y
) (
  input  logic signed [w_in-1:0]     tap,
  input  logic signed [c_in-1:0]     coef,
  output logic signed [w_muti_y-1:0] prod
);

  // Exact product needs w_in + c_in bits; both operands are signed, so the
  // multiply is evaluated signed in that width.
  logic signed [w_in+c_in-1:0] full;

  assign full = tap * coef;
  assign prod = w_muti_y'(full);

endmodule

// File: rtl/fir_src.sv
// Four-tap direct-form FIR filter, one sample per clock, registered output.
//   clk  : clock, all state updates on the rising edge
//   rstn : asynchronous reset, ACTIVE HIGH despite the name; clears taps and y_k
//   bus  : fir_src_if.slave -- x_in, c_0..c_3 in, y_k out
// Coefficients are used live (not latched). A sample captured at edge N shows
// up through c_0 on y_k after edge N+1.
module fir_src
  import fir_src_pkg::*;
#(
  parameter int w_in     = def_w_in,
  parameter int c_in     = def_c_in,
  parameter int y_out    = def_y_out,
  parameter int w_muti_y = def_w_muti_y,
  parameter int w_add_y  = def_w_add_y
) (
  input logic        clk,
  input logic        rstn,
  fir_src_if.slave   bus
);

  logic signed [w_in-1:0]     taps  [n_taps];
  logic signed [c_in-1:0]     coefs [n_taps];
  logic signed [w_muti_y-1:0] prods [n_taps];
  logic signed [w_add_y-1:0]  sum;

  assign coefs[0] = bus.c_0;
  assign coefs[1] = bus.c_1;
  assign coefs[2] = bus.c_2;
  assign coefs[3] = bus.c_3;

  for (genvar i = 0; i < n_taps; i++) begin : g_tap
    fir_mac_tap #(
      .w_in     (w_in),
      .c_in     (c_in),
      .w_muti_y (w_muti_y)
    ) u_tap (
      .tap  (taps[i]),
      .coef (coefs[i]),
      .prod (prods[i])
    );
  end

  // NOTE: every variable written in always_comb gets a default before any
  // conditional/loop update, otherwise a latch is inferred.
  always_comb begin
    sum = '0;
    for (int i = 0; i < n_taps; i++) begin
      sum = sum + w_add_y'(prods[i]);  // signed cast sign-extends
    end
  end

  // NOTE: sequential state uses non-blocking assignments so the delay line
  // shifts by exactly one stage per edge regardless of statement order.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      taps    <= '{default: '0};
      bus.y_k <= '0;
    end else begin
      taps[0] <= bus.x_in;
      for (int i = 1; i < n_taps; i++) begin
        taps[i] <= taps[i-1];
      end
      // Sum reflects the taps held before this edge; low bits kept if narrower.
      bus.y_k <= y_out'(sum);
    end
  end

endmodule

// File: tb/tb_fir_src.sv
// Scoreboard bench for fir_src: stimulus pushes the hand-computed (or, for the
// random run, reference-model) result of each clock edge; a monitor pops one
// entry per falling edge and compares it against y_k.
module tb_fir_src;
  import fir_src_pkg::*;

  typedef struct {
    string name;
    int    exp;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;

  fir_src_if bus ();

  fir_src dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic signed [31:0] act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: one comparison per falling edge when an expectation is pending.
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check(mon_e.name, 32'(bus.y_k), mon_e.exp);
      end
    end
  end

  task automatic set_coef(input int c0, input int c1, input int c2, input int c3);
    bus.c_0 = def_c_in'(c0);
    bus.c_1 = def_c_in'(c1);
    bus.c_2 = def_c_in'(c2);
    bus.c_3 = def_c_in'(c3);
  endtask

  // Drive one sample, let one edge happen, record what y_k must hold after it.
  task automatic cyc(input string name, input int x, input int exp);
    bus.x_in = def_w_in'(x);
    @(posedge clk);
    sb.push_back('{name, exp});
    #1;
  endtask

  // Short reset pulse placed between edges: only an asynchronous clear sees it.
  task automatic pulse_reset();
    @(negedge clk);
    #1 rstn = 1'b1;
    #2 rstn = 1'b0;
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int model_taps [n_taps];
  int cf [n_taps];
  int rexp;
  int rx;

  initial begin
    rstn     = 1'b1;
    bus.x_in = '0;
    set_coef(1, 1, 2, 3);

    // Reset held with a live input: output stays 0.
    for (int i = 0; i < 4; i++) cyc("reset_hold", 5, 0);
    rstn = 1'b0;

    // Impulse response: first edge loads t0 only, then taps walk c0..c3.
    cyc("impulse_0", 1, 0);
    cyc("impulse_1", 0, 1);
    cyc("impulse_2", 0, 1);
    cyc("impulse_3", 0, 2);
    cyc("impulse_4", 0, 3);
    cyc("impulse_5", 0, 0);
    cyc("impulse_6", 0, 0);

    // Step response, then mid-stream reset and restart of the ramp.
    pulse_reset();
    cyc("step_0", 5, 0);
    cyc("step_1", 5, 5);
    cyc("step_2", 5, 10);
    cyc("step_3", 5, 20);
    cyc("step_4", 5, 35);
    cyc("step_5", 5, 35);
    pulse_reset();
    cyc("restart_0", 5, 0);
    cyc("restart_1", 5, 5);
    cyc("restart_2", 5, 10);
    cyc("restart_3", 5, 20);
    cyc("restart_4", 5, 35);
    cyc("restart_5", 5, 35);

    // Extremes: most negative coefficient and sample -> largest positive sum.
    pulse_reset();
    set_coef(-16, -16, -16, -16);
    cyc("ext_neg_0", -64, 0);
    cyc("ext_neg_1", -64, 1024);
    cyc("ext_neg_2", -64, 2048);
    cyc("ext_neg_3", -64, 3072);
    cyc("ext_neg_4", -64, 4096);
    cyc("ext_neg_5", -64, 4096);

    pulse_reset();
    set_coef(15, 15, 15, 15);
    cyc("ext_pos_0", -64, 0);
    cyc("ext_pos_1", -64, -960);
    cyc("ext_pos_2", -64, -1920);
    cyc("ext_pos_3", -64, -2880);
    cyc("ext_pos_4", -64, -3840);
    cyc("ext_pos_5", -64, -3840);

    // Random samples against a cycle-level reference model.
    pulse_reset();
    set_coef(1, 1, 2, 3);
    cf = '{1, 1, 2, 3};
    model_taps = '{0, 0, 0, 0};
    for (int n = 0; n < 1000; n++) begin
      rx   = int'($urandom_range(14, 0));
      rexp = 0;
      for (int i = 0; i < n_taps; i++) rexp += cf[i] * model_taps[i];
      for (int i = n_taps - 1; i > 0; i--) model_taps[i] = model_taps[i-1];
      model_taps[0] = rx;
      cyc("random", rx, rexp);
    end

    // Every expectation must have been consumed by the monitor.
    @(negedge clk);
    #1;
    check("scoreboard_drain", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
